// File: rtl/alu_mem_sequencer.sv
// alu_mem_sequencer: multi-cycle command sequencer for the register-file / ALU / memory datapath.
// Datapath drives decode from the latched command and state, so async reset drops them at once.
module alu_mem_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd,
   output logic [4:0]       BrA1,
   output logic [4:0]       BrA2,
   output logic [4:0]       BrDDir,
   output logic [31:0]      BrDin,
   output logic             BrEwr,
   output logic [2:0]       AluSel,
   input  logic             AluZF,
   output logic [4:0]       MemDir,
   output logic             MemEwr,
   input  logic [31:0]      MemDout,
   output logic             done,
   output logic             err,
   output logic             zf,
   output logic [CNT_W-1:0] cmd_count
);
   typedef enum logic [2:0] {IDLE, EXEC, MEMW, LOAD, WB, DONE} state_t;
   state_t           state_q;
   logic [19:0]      cmd_q;
   logic [31:0]      wb_q;
   logic             zf_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       op;
   logic [4:0]       ra, rb, rd;
   logic             alu_ph;
   assign op     = cmd_q[19:18];
   assign ra     = cmd_q[17:13];
   assign rb     = cmd_q[12:8];
   assign rd     = cmd_q[7:3];
   assign alu_ph = state_q == EXEC || state_q == MEMW;
   always_comb begin
      cmd_ready = state_q == IDLE && !rst;
      BrA1      = alu_ph ? ra : '0;
      BrA2      = alu_ph ? rb : '0;
      AluSel    = alu_ph ? cmd_q[2:0] : '0;
      MemDir    = state_q == MEMW ? rd : state_q == LOAD ? ra : '0;
      MemEwr    = state_q == MEMW;
      BrDDir    = state_q == WB ? rd : '0;
      BrEwr     = state_q == WB && rd != 5'd0;
      BrDin     = BrEwr ? wb_q : '0;
      done      = state_q == DONE;
      err       = done && op == 2'b11;
      zf        = zf_q;
      cmd_count = cnt_q;
   end
   // wb_q takes the immediate at accept; LOAD_REG overwrites it with memory data
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         wb_q    <= '0;
         zf_q    <= 1'b0;
         cnt_q   <= '0;
      end else
         case (state_q)
            IDLE: if (cmd_valid) begin
               cmd_q   <= cmd[31:12];
               wb_q    <= {20'b0, cmd[11:0]};
               state_q <= cmd[31:30] == 2'b00 ? EXEC : cmd[31:30] == 2'b01 ? LOAD :
                          cmd[31:30] == 2'b10 ? WB : DONE;
            end
            EXEC: begin
               zf_q    <= AluZF;
               state_q <= MEMW;
            end
            MEMW: state_q <= DONE;
            LOAD: begin
               wb_q    <= MemDout;
               state_q <= WB;
            end
            WB: state_q <= DONE;
            default: begin
               cnt_q   <= cnt_q + CNT_W'(1);
               state_q <= IDLE;
            end
         endcase
endmodule

// File: tb/tb_alu_mem_sequencer.sv
// tb_alu_mem_sequencer: environment register file / ALU / memory around the sequencer,
// with expected completions queued at issue and checked by a monitor on each done.
module tb_alu_mem_sequencer;
   localparam int CW = 8;
   logic          clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
   logic [31:0]   cmd = '0;
   logic          cmd_ready, BrEwr, MemEwr, AluZF, done, err, zf;
   logic [4:0]    BrA1, BrA2, BrDDir, MemDir;
   logic [31:0]   BrDin, MemDout, alu_y;
   logic [2:0]    AluSel;
   logic [CW-1:0] cmd_count;
   logic          outs_nz;
   typedef struct {
      logic [1:0]    kind;
      logic [4:0]    addr;
      logic [31:0]   data;
      logic          err;
      logic          zf;
      int            lat;
      int            acc;
      logic [CW-1:0] cnt;
   } item_t;
   item_t       sb[$];
   int          n_cmp = 0, n_fail = 0, cyc = 0, exp_cnt = 0, wraps = 0;
   logic [31:0] rf [32] = '{default: '0};
   logic [31:0] mem [32] = '{default: '0};
   logic [31:0] ref_rf [32] = '{default: '0};
   logic [31:0] ref_mem [32] = '{default: '0};
   logic        ref_zf = 1'b0;

   alu_mem_sequencer #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
      .BrA1(BrA1), .BrA2(BrA2), .BrDDir(BrDDir), .BrDin(BrDin), .BrEwr(BrEwr),
      .AluSel(AluSel), .AluZF(AluZF), .MemDir(MemDir), .MemEwr(MemEwr), .MemDout(MemDout),
      .done(done), .err(err), .zf(zf), .cmd_count(cmd_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu(logic [31:0] a, logic [31:0] b, logic [2:0] s);
      case (s)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a << b[4:0];
         3'd6: return a >> b[4:0];
         default: return ~(a | b);
      endcase
   endfunction

   assign alu_y   = alu(rf[BrA1], rf[BrA2], AluSel);
   assign AluZF   = alu_y == 32'd0;
   assign MemDout = mem[MemDir];
   assign outs_nz = |{BrA1, BrA2, BrDDir, BrDin, BrEwr, AluSel, MemDir, MemEwr, done, err, zf, cmd_count};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (BrEwr && BrDDir != 5'd0) rf[BrDDir] <= BrDin;
      if (MemEwr) mem[MemDir] <= alu_y;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic item_t mk(logic [1:0] k, logic [4:0] a, logic [31:0] d, logic er, logic z, int l);
      item_t e;
      e.kind = k; e.addr = a; e.data = d; e.err = er; e.zf = z; e.lat = l; e.acc = 0; e.cnt = '0;
      return e;
   endfunction

   function automatic logic [31:0] mkc(logic [1:0] op, logic [4:0] ra, logic [4:0] rb, logic [4:0] rd,
                                       logic [2:0] sel, logic [11:0] imm);
      return {op, ra, rb, rd, sel, imm};
   endfunction

   function automatic item_t predict(logic [31:0] c);
      logic [31:0] y;
      y = alu(ref_rf[c[29:25]], ref_rf[c[24:20]], c[14:12]);
      case (c[31:30])
         2'b00: return mk(2'd2, c[19:15], y, 1'b0, y == 32'd0, 2);
         2'b01: return c[19:15] == 5'd0 ? mk(2'd0, 5'd0, 32'd0, 1'b0, ref_zf, 2)
                                        : mk(2'd1, c[19:15], ref_mem[c[29:25]], 1'b0, ref_zf, 2);
         2'b10: return c[19:15] == 5'd0 ? mk(2'd0, 5'd0, 32'd0, 1'b0, ref_zf, 1)
                                        : mk(2'd1, c[19:15], {20'b0, c[11:0]}, 1'b0, ref_zf, 1);
         default: return mk(2'd0, 5'd0, 32'd0, 1'b1, ref_zf, 0);
      endcase
   endfunction

   // waits for ready at a falling edge, presents c for the next rising edge, queues e
   task automatic issue(input logic [31:0] c, input item_t e, input logic hold);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin
         if (hold) cmd = $urandom;
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ready_timeout: cmd_ready=0 after %0d cycles, expected 1", n);
         return;
      end
      cmd = c;
      cmd_valid = 1'b1;
      e.acc = cyc + 1;
      e.cnt = CW'(exp_cnt);
      sb.push_back(e);
      if (e.kind == 2'd1) ref_rf[e.addr] = e.data;
      if (e.kind == 2'd2) ref_mem[e.addr] = e.data;
      ref_zf = e.zf;
      exp_cnt++;
      @(posedge clk);
      #1;
      cmd_valid = hold;
      cmd = $urandom;
   endtask

   initial begin : monitor
      item_t         e;
      logic [1:0]    wk;
      logic [4:0]    wa;
      logic [31:0]   wd;
      int            wn;
      logic [CW-1:0] pc;
      wk = '0; wa = '0; wd = '0; wn = 0; pc = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (BrEwr || MemEwr) chk("enable_overlap", 64'(BrEwr && MemEwr), 64'(0));
            if (BrEwr) begin wn++; wk = 2'd1; wa = BrDDir; wd = BrDin; end
            if (MemEwr) begin wn++; wk = 2'd2; wa = MemDir; wd = alu_y; end
            if (done) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_done: done=1 with no command outstanding, expected 0");
               end else begin
                  e = sb.pop_front();
                  chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                  chk("err", 64'(err), 64'(e.err));
                  chk("zf", 64'(zf), 64'(e.zf));
                  chk("count", 64'(cmd_count), 64'(e.cnt));
                  chk("nwrites", 64'(wn), 64'(e.kind != 2'd0));
                  chk("write", 64'({wk, wa, wd}), 64'({e.kind, e.addr, e.data}));
               end
               if (cmd_count < pc) wraps++;
               pc = cmd_count;
               wn = 0; wk = '0; wa = '0; wd = '0;
            end
         end
      end
   end

   initial begin : stim
      logic [31:0] c;
      int          n;
      repeat (2) @(negedge clk);
      chk("ready_in_rst", 64'(cmd_ready), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("rst_outputs", 64'(outs_nz), 64'(0));
      chk("ready_after_rst", 64'(cmd_ready), 64'(1));
      // ALU_STORE aborted by reset while in MEMW
      cmd = mkc(2'd0, 5'd0, 5'd0, 5'd1, 3'd0, 12'd0);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("memw_ewr", 64'(MemEwr), 64'(1));
      rst = 1'b1;
      #1;
      chk("rst_drops_ewr", 64'(MemEwr), 64'(0));
      chk("rst_clears", 64'(outs_nz), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_count", 64'(cmd_count), 64'(0));
      chk("abort_zf", 64'(zf), 64'(0));
      chk("ready_after_abort", 64'(cmd_ready), 64'(1));
      // directed vectors
      issue(mkc(2'd2, 5'd0, 5'd0, 5'd3, 3'd0, 12'h0AB), mk(2'd1, 5'd3, 32'hAB, 1'b0, 1'b0, 1), 1'b0);
      issue(mkc(2'd2, 5'd0, 5'd0, 5'd4, 3'd0, 12'h0AB), mk(2'd1, 5'd4, 32'hAB, 1'b0, 1'b0, 1), 1'b0);
      issue(mkc(2'd0, 5'd3, 5'd4, 5'd7, 3'd1, 12'd0), mk(2'd2, 5'd7, 32'h0, 1'b0, 1'b1, 2), 1'b0);
      issue(mkc(2'd1, 5'd7, 5'd0, 5'd5, 3'd0, 12'd0), mk(2'd1, 5'd5, 32'h0, 1'b0, 1'b1, 2), 1'b0);
      issue(mkc(2'd0, 5'd3, 5'd4, 5'd9, 3'd0, 12'd0), mk(2'd2, 5'd9, 32'h156, 1'b0, 1'b0, 2), 1'b0);
      issue(mkc(2'd1, 5'd9, 5'd0, 5'd6, 3'd0, 12'd0), mk(2'd1, 5'd6, 32'h156, 1'b0, 1'b0, 2), 1'b0);
      issue(mkc(2'd1, 5'd9, 5'd0, 5'd0, 3'd0, 12'd0), mk(2'd0, 5'd0, 32'h0, 1'b0, 1'b0, 2), 1'b0);
      issue(mkc(2'd2, 5'd0, 5'd0, 5'd0, 3'd0, 12'hFFF), mk(2'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1), 1'b0);
      issue(mkc(2'd3, 5'd1, 5'd2, 5'd3, 3'd4, 12'h5A5), mk(2'd0, 5'd0, 32'h0, 1'b1, 1'b0, 0), 1'b0);
      // back-to-back with cmd_valid held high; enough commands to wrap the counter once
      for (int i = 0; i < 300; i++) begin
         c = $urandom;
         issue(c, predict(c), 1'b1);
      end
      cmd_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(sb.size()), 64'(0));
      @(negedge clk);
      chk("final_count", 64'(cmd_count), 64'(CW'(exp_cnt)));
      chk("wraps", 64'(wraps), 64'(1));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_mem_sequencer.md
# alu_mem_sequencer

Multi-cycle command sequencer that drives the register-file / ALU / 32x32 memory datapath. It accepts one 32-bit command at a time over a valid/ready handshake and steps the datapath through read, execute, memory-write, memory-read and write-back phases. It holds every datapath control stable for whole cycles and pulses write enables for exactly one cycle. It reports completion, the captured ALU zero flag, an error flag and a completed-command count.

## Interface
- CNT_W, 16, width of the completed-command counter (wraps)
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command word present
- cmd_ready  out  1  sequencer can accept; high only in IDLE and with rst low
- cmd  in  32  command: op[31:30], ra[29:25], rb[24:20], rd[19:15] (register or memory address), sel[14:12], imm[11:0]
- BrA1, BrA2  out  5 each  register-file read addresses
- BrDDir  out  5  register-file write address
- BrDin  out  32  register-file write data
- BrEwr  out  1  register-file write enable (one-cycle pulse)
- AluSel  out  3  ALU operation select
- AluZF  in  1  ALU zero flag
- MemDir  out  5  memory address
- MemEwr  out  1  memory write enable (one-cycle pulse)
- MemDout  in  32  memory read data
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = reserved op, no writes performed
- zf  out  1  ALU zero flag captured at the last ALU_STORE
- cmd_count  out  CNT_W  number of completed commands, including errored ones

## Operation
- Accept when cmd_valid & cmd_ready. Latch cmd into an internal register. The datapath outputs come only from the latched copy, never from cmd directly.
- Ops:
  - 00 ALU_STORE: mem[rd] = ALU(reg[ra], reg[rb], sel).
  - 01 LOAD_REG: reg[rd] = mem[ra].
  - 10 LOAD_IMM: reg[rd] = {20'b0, imm}.
  - 11 reserved: error.
- States and transitions:
  - IDLE: on accept, go to EXEC (op 00), LOAD (op 01), WB (op 10) or DONE with err (op 11).
  - EXEC: BrA1=ra, BrA2=rb, AluSel=sel. Sample AluZF into zf at the end of the cycle. Next state MEMW.
  - MEMW: keep the EXEC drives; MemDir=rd, MemEwr=1. Next state DONE.
  - LOAD: MemDir=ra, MemEwr=0. Capture MemDout into the write-back data register at the end of the cycle. Next state WB.
  - WB: BrDDir=rd, BrDin=write-back data, BrEwr=1. Next state DONE.
  - DONE: done=1; err=1 only for op 11. Increment cmd_count. Next state IDLE.
- Register 0 is hardwired zero: in WB with rd=0, BrEwr stays 0. The command still completes normally with err=0.
- MemEwr and BrEwr are never both high. Neither is high outside MEMW/WB.
- cmd_count increments by 1 modulo 2^CNT_W, so all-ones wraps to 0.
- Unused outputs are 0 in every state: addresses, AluSel, BrDin, and enables outside their phases.
- Reset, including mid-command:
  - State returns to IDLE; every output and every internal register is cleared to 0.
  - No partial write is left pending. A write enable that was high drops immediately (asynchronously).
  - The interrupted command is discarded: no done and no count increment.

## Timing
- Let the accept edge be T0.
  - ALU_STORE: EXEC in T0–T1, MEMW in T1–T2, done high in T2–T3.
  - LOAD_REG: LOAD in T0–T1, WB in T1–T2, done high in T2–T3.
  - LOAD_IMM: WB in T0–T1, done high in T1–T2.
  - Reserved: done and err high in T0–T1.
- cmd_ready goes low the cycle after accept. It returns high the cycle after done.
- Back-to-back throughput: one command per (latency + 1) cycles. There is no overlap of commands.
- cmd_valid may stay high while cmd_ready is low; the command is held and not consumed. cmd may change freely while cmd_ready is low.
- zf updates only at the end of EXEC and holds otherwise.

## Test plan
- Reset release: all outputs read 0 and cmd_ready=1.
  - Assert rst during MEMW -> MemEwr drops at once, no done, cmd_count stays 0.
- LOAD_IMM rd=3, imm=0x0AB, then LOAD_IMM rd=4, imm=0x0AB.
  - Each gives a one-cycle BrEwr with BrDDir=3 (then 4) and BrDin=0x000000AB.
  - done arrives 2 cycles after accept; cmd_count=2.
- ALU_STORE ra=3, rb=4, sel=subtract, rd=7 with the above registers.
  - MemEwr pulses with MemDir=7, zf=1, done=1, err=0.
  - Then LOAD_REG ra=7, rd=5 -> BrDin=0 written to reg 5.
- LOAD_IMM rd=0, imm=0xFFF -> BrEwr never asserts, done=1, err=0.
- Op 11 -> done and err high one cycle after accept, no BrEwr/MemEwr, cmd_count increments.
- Hold cmd_valid high with random cmds for 70000 commands:
  - One accept per idle cycle; no enable overlap.
  - cmd_count wraps 0xFFFF -> 0x0000 exactly once.
